// File: rtl/multiplexer_rr_n_pkg.sv
// Shared definitions for the registered N-way bus multiplexer: mode encodings
// and the ceil(log2) helper used to validate the select width.
package multiplexer_rr_n_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    function automatic int mux_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/multiplexer_rr_n_if.sv
// Handshake/bus bundle between a producer (master) and the multiplexer (slave).
interface multiplexer_rr_n_if #(
    parameter int NUM_INPUTS = 4,
    parameter int WIDTH      = 8,
    parameter int SEL_W      = 2
);
    logic                        enable;
    logic                        mode;
    logic [SEL_W-1:0]            sel;
    logic [NUM_INPUTS-1:0]       req;
    logic [NUM_INPUTS*WIDTH-1:0] mux_in;
    logic                        out_ready;
    logic [WIDTH-1:0]            mux_out;
    logic                        out_valid;
    logic [NUM_INPUTS-1:0]       grant;
    logic [SEL_W-1:0]            grant_idx;

    modport master (
        output enable, mode, sel, req, mux_in, out_ready,
        input  mux_out, out_valid, grant, grant_idx
    );

    modport slave (
        input  enable, mode, sel, req, mux_in, out_ready,
        output mux_out, out_valid, grant, grant_idx
    );
endinterface

// File: rtl/multiplexer_rr_n_rr_arbiter.sv
// Round-robin arbiter: combinational winner search starting after the pointer,
// with the pointer register updated only when the caller commits a grant.
module rr_arbiter_n #(
    parameter int NUM_INPUTS = 4,
    parameter int SEL_W      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_INPUTS-1:0] req_i,
    input  logic                  advance_i,
    output logic [NUM_INPUTS-1:0] grant_oh_o,
    output logic [SEL_W-1:0]      grant_idx_o,
    output logic                  any_o
);
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] win_idx;
    logic             any;
    logic [SEL_W:0]   cand;

    // Scan ptr+1, ptr+2, ... wrapping modulo NUM_INPUTS; first requester wins.
    always_comb begin
        any     = 1'b0;
        win_idx = ptr_q;
        cand    = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            cand = {1'b0, ptr_q} + (SEL_W+1)'(k);
            if (cand >= (SEL_W+1)'(NUM_INPUTS)) begin
                cand = cand - (SEL_W+1)'(NUM_INPUTS);
            end
            if (!any && req_i[cand[SEL_W-1:0]]) begin
                any     = 1'b1;
                win_idx = cand[SEL_W-1:0];
            end
        end
    end

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_onehot
        assign grant_oh_o[gi] = any && (win_idx == SEL_W'(gi));
    end

    assign grant_idx_o = win_idx;
    assign any_o       = any;
    assign ptr_d       = advance_i ? win_idx : ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= SEL_W'(NUM_INPUTS - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/multiplexer_rr_n.sv
// Registered N-way WIDTH-bit bus multiplexer with direct (Sel) and round-robin
// (Req) source selection feeding a single valid/ready output register.
module multiplexer_rr_n
    import multiplexer_rr_n_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int WIDTH      = 8,
    parameter int SEL_W      = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    multiplexer_rr_n_if.slave mux_if
);
    localparam int IW = mux_clog2(NUM_INPUTS * WIDTH);

    if (SEL_W != mux_clog2(NUM_INPUTS)) begin : g_bad_sel_w
        $error("multiplexer_rr_n: SEL_W must equal clog2(NUM_INPUTS)");
    end
    if (NUM_INPUTS < 2 || NUM_INPUTS > 16) begin : g_bad_num_inputs
        $error("multiplexer_rr_n: NUM_INPUTS must be within 2..16");
    end

    logic [WIDTH-1:0]      mux_out_q,   mux_out_d;
    logic                  out_valid_q, out_valid_d;
    logic [NUM_INPUTS-1:0] grant_q,     grant_d;
    logic [SEL_W-1:0]      grant_idx_q, grant_idx_d;

    logic                  load;
    logic                  advance;
    logic [SEL_W-1:0]      sel_c;
    logic [SEL_W-1:0]      src_idx;
    logic [IW-1:0]         base;
    logic [WIDTH-1:0]      word;
    logic [NUM_INPUTS-1:0] arb_grant_oh;
    logic [SEL_W-1:0]      arb_idx;
    logic                  arb_any;

    assign load    = ~out_valid_q | mux_if.out_ready;
    assign advance = load & mux_if.enable & (mux_if.mode == MODE_RR) & arb_any;

    rr_arbiter_n #(
        .NUM_INPUTS (NUM_INPUTS),
        .SEL_W      (SEL_W)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (mux_if.req),
        .advance_i   (advance),
        .grant_oh_o  (arb_grant_oh),
        .grant_idx_o (arb_idx),
        .any_o       (arb_any)
    );

    // Out-of-range Sel falls through to the last channel.
    always_comb begin
        sel_c = mux_if.sel;
        if ({1'b0, mux_if.sel} >= (SEL_W+1)'(NUM_INPUTS)) begin
            sel_c = SEL_W'(NUM_INPUTS - 1);
        end
    end

    always_comb begin
        src_idx = (mux_if.mode == MODE_RR) ? arb_idx : sel_c;
        base    = IW'(int'(src_idx) * WIDTH);
        word    = mux_if.mux_in[base +: WIDTH];
    end

    // Stall holds everything except Grant, which only pulses on a load edge.
    always_comb begin
        mux_out_d   = mux_out_q;
        out_valid_d = out_valid_q;
        grant_idx_d = grant_idx_q;
        grant_d     = '0;
        if (load) begin
            if (!mux_if.enable) begin
                out_valid_d = 1'b0;
                mux_out_d   = '0;
            end else if (mux_if.mode == MODE_DIRECT) begin
                mux_out_d   = word;
                out_valid_d = 1'b1;
                grant_idx_d = sel_c;
            end else if (arb_any) begin
                mux_out_d   = word;
                out_valid_d = 1'b1;
                grant_idx_d = arb_idx;
                grant_d     = arb_grant_oh;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mux_out_q   <= '0;
            out_valid_q <= 1'b0;
            grant_q     <= '0;
            grant_idx_q <= '0;
        end else begin
            mux_out_q   <= mux_out_d;
            out_valid_q <= out_valid_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign mux_if.mux_out   = mux_out_q;
    assign mux_if.out_valid = out_valid_q;
    assign mux_if.grant     = grant_q;
    assign mux_if.grant_idx = grant_idx_q;
endmodule

// File: tb/tb_multiplexer_rr_n.sv
// Vector-table bench for multiplexer_rr_n: a 4-input and a 3-input instance,
// expectations queued at drive time and compared after the capturing edge.
module tb_multiplexer_rr_n;

    typedef struct {
        logic        en;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  req;
        logic [31:0] din;
        logic        rdy;
        logic        ev;
        logic [7:0]  eout;
        logic [3:0]  eg;
        logic [1:0]  eidx;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multiplexer_rr_n_if #(.NUM_INPUTS(4), .WIDTH(8), .SEL_W(2)) if4 ();
    multiplexer_rr_n_if #(.NUM_INPUTS(3), .WIDTH(8), .SEL_W(2)) if3 ();

    multiplexer_rr_n #(.NUM_INPUTS(4), .WIDTH(8), .SEL_W(2)) dut4 (
        .clk_i  (clk),
        .rst_i  (rst),
        .mux_if (if4.slave)
    );

    multiplexer_rr_n #(.NUM_INPUTS(3), .WIDTH(8), .SEL_W(2)) dut3 (
        .clk_i  (clk),
        .rst_i  (rst),
        .mux_if (if3.slave)
    );

    vec_t sb_q[$];
    vec_t tab4[$];
    vec_t tab3[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    localparam logic [31:0] D  = 32'h4433_2211;
    localparam logic [31:0] E  = 32'hAABB_CCDD;
    localparam logic [31:0] D3 = 32'h00CC_BBAA;

    function automatic vec_t mk(logic en, logic mode, logic [1:0] sel, logic [3:0] req,
                                logic [31:0] din, logic rdy, logic ev, logic [7:0] eout,
                                logic [3:0] eg, logic [1:0] eidx);
        vec_t v;
        v.en = en; v.mode = mode; v.sel = sel; v.req = req; v.din = din; v.rdy = rdy;
        v.ev = ev; v.eout = eout; v.eg = eg; v.eidx = eidx;
        return v;
    endfunction

    task automatic check(input string nm, input logic av, input logic [7:0] ao,
                         input logic [3:0] ag, input logic [1:0] ai, input vec_t e);
        n_vec++;
        if (av !== e.ev || ao !== e.eout || ag !== e.eg || ai !== e.eidx) begin
            n_miss++;
            $display("FAIL %s: got valid=%b out=%h grant=%b idx=%0d, expected valid=%b out=%h grant=%b idx=%0d",
                     nm, av, ao, ag, ai, e.ev, e.eout, e.eg, e.eidx);
        end else begin
            $display("ok   %s: valid=%b out=%h grant=%b idx=%0d", nm, av, ao, ag, ai);
        end
    endtask

    task automatic drive4(input vec_t v);
        if4.enable    = v.en;
        if4.mode      = v.mode;
        if4.sel       = v.sel;
        if4.req       = v.req;
        if4.mux_in    = v.din;
        if4.out_ready = v.rdy;
    endtask

    task automatic drive3(input vec_t v);
        if3.enable    = v.en;
        if3.mode      = v.mode;
        if3.sel       = v.sel;
        if3.req       = v.req[2:0];
        if3.mux_in    = v.din[23:0];
        if3.out_ready = v.rdy;
    endtask

    task automatic step4(input vec_t v, input string nm);
        vec_t e;
        drive4(v);
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(nm, if4.out_valid, if4.mux_out, if4.grant, if4.grant_idx, e);
    endtask

    task automatic step3(input vec_t v, input string nm);
        vec_t e;
        drive3(v);
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(nm, if3.out_valid, if3.mux_out, {1'b0, if3.grant}, if3.grant_idx, e);
    endtask

    initial begin
        // Direct mode, including Sel=3 on the 4-input instance.
        tab4.push_back(mk(1, 0, 2, 4'b0000, D, 1, 1, 8'h33, 4'b0000, 2));
        tab4.push_back(mk(1, 0, 0, 4'b0000, D, 1, 1, 8'h11, 4'b0000, 0));
        tab4.push_back(mk(1, 0, 3, 4'b1111, D, 1, 1, 8'h44, 4'b0000, 3));
        // Round-robin sweep from the reset pointer.
        tab4.push_back(mk(1, 1, 0, 4'b1111, D, 1, 1, 8'h11, 4'b0001, 0));
        tab4.push_back(mk(1, 1, 0, 4'b1111, D, 1, 1, 8'h22, 4'b0010, 1));
        tab4.push_back(mk(1, 1, 0, 4'b1111, D, 1, 1, 8'h33, 4'b0100, 2));
        tab4.push_back(mk(1, 1, 0, 4'b1111, D, 1, 1, 8'h44, 4'b1000, 3));
        tab4.push_back(mk(1, 1, 0, 4'b1111, D, 1, 1, 8'h11, 4'b0001, 0));
        // No requester, then disabled, then pointer resumes after 0.
        tab4.push_back(mk(1, 1, 0, 4'b0000, D, 1, 0, 8'h11, 4'b0000, 0));
        tab4.push_back(mk(0, 1, 0, 4'b1111, D, 1, 0, 8'h00, 4'b0000, 0));
        tab4.push_back(mk(1, 1, 0, 4'b1111, D, 1, 1, 8'h22, 4'b0010, 1));
        // Direct interval keeps the pointer.
        tab4.push_back(mk(1, 0, 3, 4'b1111, D, 1, 1, 8'h44, 4'b0000, 3));
        tab4.push_back(mk(1, 1, 0, 4'b1111, D, 1, 1, 8'h33, 4'b0100, 2));
        // Lone requesters, including wrap to channel 0.
        tab4.push_back(mk(1, 1, 0, 4'b0010, D, 1, 1, 8'h22, 4'b0010, 1));
        tab4.push_back(mk(1, 1, 0, 4'b0010, D, 1, 1, 8'h22, 4'b0010, 1));
        tab4.push_back(mk(1, 1, 0, 4'b0001, D, 1, 1, 8'h11, 4'b0001, 0));
        // Capture channel 1, stall three cycles under changing inputs, release.
        tab4.push_back(mk(1, 1, 0, 4'b0010, D, 1, 1, 8'h22, 4'b0010, 1));
        tab4.push_back(mk(1, 1, 0, 4'b1111, E, 0, 1, 8'h22, 4'b0000, 1));
        tab4.push_back(mk(0, 1, 0, 4'b1111, E, 0, 1, 8'h22, 4'b0000, 1));
        tab4.push_back(mk(1, 0, 3, 4'b0101, E, 0, 1, 8'h22, 4'b0000, 1));
        tab4.push_back(mk(1, 1, 0, 4'b1111, E, 1, 1, 8'hBB, 4'b0100, 2));

        tab3.push_back(mk(1, 0, 3, 4'b0000, D3, 1, 1, 8'hCC, 4'b0000, 2));
        tab3.push_back(mk(1, 0, 1, 4'b0000, D3, 1, 1, 8'hBB, 4'b0000, 1));
        tab3.push_back(mk(1, 1, 0, 4'b0111, D3, 1, 1, 8'hAA, 4'b0001, 0));
        tab3.push_back(mk(1, 1, 0, 4'b0111, D3, 1, 1, 8'hBB, 4'b0010, 1));
        tab3.push_back(mk(1, 1, 0, 4'b0111, D3, 1, 1, 8'hCC, 4'b0100, 2));
        tab3.push_back(mk(1, 1, 0, 4'b0111, D3, 1, 1, 8'hAA, 4'b0001, 0));
        tab3.push_back(mk(1, 1, 0, 4'b0100, D3, 1, 1, 8'hCC, 4'b0100, 2));

        // Reset dominates even with a live selection presented.
        drive3(mk(0, 0, 0, 4'b0000, D3, 1, 0, 8'h00, 4'b0000, 0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        step4(mk(1, 0, 2, 4'b1111, D, 1, 0, 8'h00, 4'b0000, 0), "reset4");
        check("reset3", if3.out_valid, if3.mux_out, {1'b0, if3.grant}, if3.grant_idx,
              mk(0, 0, 0, 4'b0000, 0, 0, 0, 8'h00, 4'b0000, 0));
        rst = 1'b0;

        for (int i = 0; i < tab4.size(); i++) begin
            step4(tab4[i], $sformatf("n4_vec%0d", i));
        end

        // Reset while full and stalled: pointer returns to NUM_INPUTS-1.
        step4(mk(1, 1, 0, 4'b1000, E, 0, 1, 8'hBB, 4'b0000, 2), "stall_pre_rst");
        rst = 1'b1;
        step4(mk(1, 1, 0, 4'b1111, E, 0, 0, 8'h00, 4'b0000, 0), "rst_mid_hs");
        rst = 1'b0;
        step4(mk(1, 1, 0, 4'b1111, D, 1, 1, 8'h11, 4'b0001, 0), "post_rst_rr0");
        step4(mk(1, 1, 0, 4'b1111, D, 1, 1, 8'h22, 4'b0010, 1), "post_rst_rr1");

        for (int i = 0; i < tab3.size(); i++) begin
            step3(tab3[i], $sformatf("n3_vec%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
